// File: rtl/mult_booth4_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier.
// Build option: define MULT_OVF_EXC_EN to enable the signed-32 overflow exception.
package mult_booth4_pkg;

   localparam int WIDTH  = 32;
   localparam int ITERS  = WIDTH / 2;
   localparam int ACC_W  = WIDTH + 2;
   localparam int PREG_W = ACC_W + WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   typedef enum logic [2:0] {
      ZERO,
      ADD1,
      ADD2,
      SUB1,
      SUB2
   } booth_op_e;

   // Two-bit arithmetic right shift widened to the full product register.
   function automatic logic [PREG_W-1:0] asr2(input logic [PREG_W-1:0] v);
      return {{2{v[PREG_W-1]}}, v[PREG_W-1:2]};
   endfunction

endpackage

// File: rtl/mult_booth4_booth_recode.sv
// Radix-4 Booth recoder: three overlapping multiplier bits select the addend.
module booth_recode
   import mult_booth4_pkg::*;
(
   input  logic [2:0] bits_i,
   output booth_op_e  op_o
);

   always_comb begin
      op_o = ZERO;
      case (bits_i)
         3'b001, 3'b010: op_o = ADD1;
         3'b011:         op_o = ADD2;
         3'b100:         op_o = SUB2;
         3'b101, 3'b110: op_o = SUB1;
         default:        op_o = ZERO;
      endcase
   end

endmodule

// File: rtl/mult_booth4.sv
// Sequential signed 32x32 radix-4 Booth multiplier, 16 iterations per product.
// Build option: MULT_OVF_EXC_EN enables data_exception; otherwise it is tied low.
module mult_booth4
   import mult_booth4_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   state_e              state_q, state_d;
   logic [PREG_W-1:0]   preg_q, preg_d;
   logic [WIDTH-1:0]    mcand_q, mcand_d;
   logic [3:0]          count_q, count_d;
   logic [WIDTH-1:0]    result_q, result_d;
   logic                exc_q, exc_d;
   logic                rdy_q, rdy_d;
   logic                busy_q, busy_d;

   booth_op_e           boothOp;
   logic [ACC_W-1:0]    mExt;
   logic [ACC_W-1:0]    addend;
   logic [ACC_W-1:0]    accSum;
   logic [PREG_W-1:0]   iterP;
   logic                ovf;

   booth_recode u_recode (
      .bits_i (preg_q[2:0]),
      .op_o   (boothOp)
   );

   always_comb begin
      mExt   = {{2{mcand_q[WIDTH-1]}}, mcand_q};
      addend = '0;
      case (boothOp)
         ADD1:    addend = mExt;
         ADD2:    addend = mExt << 1;
         SUB1:    addend = -mExt;
         SUB2:    addend = -(mExt << 1);
         default: addend = '0;
      endcase
      accSum = preg_q[PREG_W-1:WIDTH+1] + addend;
      iterP  = asr2({accSum, preg_q[WIDTH:0]});
   end

`ifdef MULT_OVF_EXC_EN
   // The full product sits in P[64:1]; it fits in 32 bits only if the upper half is pure sign.
   assign ovf = (preg_q[2*WIDTH:WIDTH+1] != {WIDTH{preg_q[WIDTH]}});
`else
   assign ovf = 1'b0;
`endif

   // A start strobe wins in every state, so an in-flight product is silently abandoned.
   always_comb begin
      state_d  = state_q;
      preg_d   = preg_q;
      mcand_d  = mcand_q;
      count_d  = count_q;
      result_d = result_q;
      exc_d    = exc_q;
      rdy_d    = 1'b0;

      if (ctrl_MULT) begin
         mcand_d = data_operandA;
         preg_d  = {{ACC_W{1'b0}}, data_operandB, 1'b0};
         count_d = '0;
         state_d = RUN;
      end else begin
         case (state_q)
            RUN: begin
               preg_d  = iterP;
               count_d = count_q + 4'd1;
               if (count_q == 4'(ITERS - 1)) begin
                  state_d = DONE;
               end
            end
            DONE: begin
               result_d = preg_q[WIDTH:1];
               exc_d    = ovf;
               rdy_d    = 1'b1;
               state_d  = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      busy_d = (state_d == RUN);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         preg_q   <= '0;
         mcand_q  <= '0;
         count_q  <= '0;
         result_q <= '0;
         exc_q    <= 1'b0;
         rdy_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         preg_q   <= preg_d;
         mcand_q  <= mcand_d;
         count_q  <= count_d;
         result_q <= result_d;
         exc_q    <= exc_d;
         rdy_q    <= rdy_d;
         busy_q   <= busy_d;
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;
   assign busy           = busy_q;

endmodule
